// File: rtl/conv_kij_sequencer.sv
// rtl/conv_kij_sequencer.sv - instruction sequencer for one full convolution pass over all kij offsets
//
// Purpose: walks core through weight fetch into L0, kernel load, gap, activation
// execute and OFIFO drain to psum SRAM for each of len_kij kernel offsets.
// Optional feature macro: CONV_SEQ_INPLACE_ACC_EN (every kij writes the same psum
// region, and acc is set on writes after the first kij).
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   start        in   one-cycle pulse, accepted only in IDLE
//   ofifo_valid  in   core has a complete OFIFO row
//   inst[33:0]   out  registered instruction word to core
//   busy         out  high whenever the FSM is not idle
//   done         out  one-cycle pulse at pass completion
//   kij_idx[3:0] out  kij currently being processed
module conv_kij_sequencer #(
  parameter int          row        = 8,
  parameter int          col        = 8,
  parameter int          len_kij    = 9,
  parameter int          len_nij    = 36,
  parameter int          gap_cycles = 10,
  parameter logic [10:0] x_base     = 11'd0,
  parameter logic [10:0] w_base     = 11'd1024,
  parameter logic [10:0] p_base     = 11'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij_idx
);

  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;
  localparam logic [7:0]  COL_END   = 8'(col);
  localparam logic [7:0]  LOAD_END  = 8'(col + row);
  localparam logic [7:0]  GAP_END   = 8'(gap_cycles - 1);
  localparam logic [7:0]  NIJ       = 8'(len_nij);
  localparam logic [3:0]  LAST_KIJ  = 4'(len_kij - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_W_L0, S_W_LOAD, S_GAP, S_X_EXEC, S_DRAIN, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  c_q, c_d;
  logic [3:0]  kij_q, kij_d;
  logic [7:0]  wr_cnt_q, wr_cnt_d;
  logic [33:0] inst_q, inst_d;
  logic        busy_q, done_q;
  logic [3:0]  kij_idx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      c_q       <= '0;
      kij_q     <= '0;
      wr_cnt_q  <= '0;
      inst_q    <= IDLE_WORD;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      kij_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      kij_q     <= kij_d;
      wr_cnt_q  <= wr_cnt_d;
      inst_q    <= inst_d;
      // Status outputs are built from the state that produced inst_d, so
      // busy/done/kij_idx stay aligned with the instruction word.
      busy_q    <= (state_q != S_IDLE);
      done_q    <= (state_q == S_FIN);
      kij_idx_q <= kij_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    c_d      = c_q + 8'd1;
    kij_d    = kij_q;
    wr_cnt_d = wr_cnt_q;
    inst_d   = IDLE_WORD;

    case (state_q)
      S_IDLE: begin
        c_d = '0;
        if (start) begin
          state_d = S_W_L0;
          kij_d   = '0;
        end
      end
      S_W_L0: begin
        if (c_q < COL_END) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = w_base + 11'(kij_q) * 11'(col) + 11'(c_q);
        end
        // L0 write trails the xmem read by one cycle (SRAM read latency).
        if (c_q != 8'd0) inst_d[2] = 1'b1;
        if (c_q == COL_END) begin
          state_d = S_W_LOAD;
          c_d     = '0;
        end
      end
      S_W_LOAD: begin
        inst_d[3] = 1'b1;
        if (c_q != 8'd0) inst_d[0] = 1'b1;
        if (c_q == LOAD_END) begin
          state_d = S_GAP;
          c_d     = '0;
        end
      end
      S_GAP: begin
        if (c_q == GAP_END) begin
          state_d = S_X_EXEC;
          c_d     = '0;
        end
      end
      S_X_EXEC: begin
        if (c_q < NIJ) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = x_base + 11'(c_q);
        end
        if (c_q != 8'd0) begin
          inst_d[3] = 1'b1;
          inst_d[2] = 1'b1;
          inst_d[1] = 1'b1;
        end
        if (c_q == NIJ) begin
          state_d = S_DRAIN;
          c_d     = '0;
        end
      end
      S_DRAIN: begin
        c_d = c_q;
        if (wr_cnt_q == NIJ) begin
          wr_cnt_d = '0;
          c_d      = '0;
          if (kij_q < LAST_KIJ) begin
            kij_d   = kij_q + 4'd1;
            state_d = S_W_L0;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        c_d     = '0;
        state_d = S_IDLE;
      end
      default: begin
        c_d     = '0;
        state_d = S_IDLE;
      end
    endcase

    // Drain write: gated on the registered ofifo_rd so core has a cycle to
    // present the next row; at most one row every two cycles.
    if ((state_q == S_X_EXEC || state_q == S_DRAIN) && ofifo_valid &&
        !inst_q[6] && (wr_cnt_q < NIJ)) begin
      inst_d[6]  = 1'b1;
      inst_d[32] = 1'b0;
      inst_d[31] = 1'b0;
`ifdef CONV_SEQ_INPLACE_ACC_EN
      inst_d[30:20] = p_base + 11'(wr_cnt_q);
      inst_d[33]    = (kij_q != 4'd0);
`else
      inst_d[30:20] = p_base + 11'(kij_q) * 11'(len_nij) + 11'(wr_cnt_q);
`endif
      wr_cnt_d = wr_cnt_q + 8'd1;
    end
  end

  assign inst    = inst_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign kij_idx = kij_idx_q;

endmodule

// File: tb/tb_conv_kij_sequencer.sv
// tb/tb_conv_kij_sequencer.sv - directed self-checking bench for conv_kij_sequencer
module tb_conv_kij_sequencer;

  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij_idx;

  int n_cmp = 0;
  int n_fail = 0;

  // Core model and write monitor state
  logic model_en = 1'b0;
  logic force_valid = 1'b0;
  logic rec_en = 1'b0;
  int   avail = 0;
  int   adj = 0;
  logic prev_rd = 1'b0;
  int   wr_addr[$];
  int   wr_acc[$];
  int   wr_rd[$];
  int   wr_kij[$];

  always #5 clk = ~clk;

  conv_kij_sequencer dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ofifo_valid(ofifo_valid),
    .inst(inst),
    .busy(busy),
    .done(done),
    .kij_idx(kij_idx)
  );

  // Model core: every execute produces one OFIFO row, every ofifo_rd consumes one.
  always @(negedge clk) begin
    if (reset) begin
      avail = 0;
    end else begin
      if (inst[1]) avail++;
      if (inst[6] && avail > 0) avail--;
    end
    if (rec_en) begin
      if (inst[6] && prev_rd) adj++;
      prev_rd = inst[6];
      if (!inst[32] && !inst[31]) begin
        wr_addr.push_back(int'(inst[30:20]));
        wr_acc.push_back(int'(inst[33]));
        wr_rd.push_back(int'(inst[6]));
        wr_kij.push_back(int'(kij_idx));
      end
    end
    ofifo_valid = force_valid || (model_en && avail > 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    rec_en = 1'b0;
    prev_rd = 1'b0;
    adj = 0;
    wr_addr.delete();
    wr_acc.delete();
    wr_rd.delete();
    wr_kij.delete();
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (inst !== IDLE_WORD) begin
      n_fail++;
      $display("FAIL reset_inst: got %h want %h", inst, IDLE_WORD);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || kij_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_status: got busy=%b done=%b kij=%0d want 0 0 0", busy, done, kij_idx);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (inst !== IDLE_WORD || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: got inst=%h busy=%b want %h 0", i, inst, busy, IDLE_WORD);
      end
    end
  endtask

  task automatic test_weight_fetch();
    logic [3:0]  exp_ctl;
    logic [3:0]  got_ctl;
    logic [10:0] exp_a;
    bit          hit;
    do_reset();
    force_valid = 1'b1;
    pulse_start();
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      tick();
      hit = (kij_idx == 4'd1) && (inst[19] == 1'b0);
    end
    n_cmp++;
    if (!hit) begin
      n_fail++;
      $display("FAIL wfetch_reach: kij=1 W_L0 not seen, got kij=%0d want 1", kij_idx);
    end else begin
      for (int i = 0; i < 27; i++) begin
        // {CEN_xmem, l0_wr, l0_rd, load}
        exp_ctl = {(i >= 8) ? 1'b1 : 1'b0,
                   (i >= 1 && i <= 8) ? 1'b1 : 1'b0,
                   (i >= 9 && i <= 25) ? 1'b1 : 1'b0,
                   (i >= 10 && i <= 25) ? 1'b1 : 1'b0};
        got_ctl = {inst[19], inst[2], inst[3], inst[0]};
        n_cmp++;
        if (got_ctl !== exp_ctl) begin
          n_fail++;
          $display("FAIL wfetch_ctl[%0d]: got %b want %b", i, got_ctl, exp_ctl);
        end
        if (i < 8) begin
          exp_a = 11'(1032 + i);
          n_cmp++;
          if (inst[17:7] !== exp_a) begin
            n_fail++;
            $display("FAIL wfetch_addr[%0d]: got %0d want %0d", i, inst[17:7], exp_a);
          end
        end
        if (i == 26) begin
          n_cmp++;
          if (inst !== IDLE_WORD) begin
            n_fail++;
            $display("FAIL wfetch_gap: got %h want %h", inst, IDLE_WORD);
          end
        end
        tick();
      end
    end
    force_valid = 1'b0;
  endtask

  task automatic test_full_pass();
    bit fin;
    int dcount;
    int exp_addr;
    int exp_acc;
    do_reset();
    model_en = 1'b1;
    rec_en = 1'b1;
    pulse_start();
    fin = 0;
    dcount = 0;
    for (int i = 0; i < 4000 && !fin; i++) begin
      tick();
      if (done) begin
        dcount++;
        fin = 1;
        n_cmp++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL pass_busy_at_done: got %b want 1", busy);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL pass_busy_fall: got busy=%b done=%b want 0 0", busy, done);
        end
      end
    end
    n_cmp++;
    if (!fin) begin
      n_fail++;
      $display("FAIL pass_done_timeout: done=%b want 1 within budget", done);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dcount++;
    end
    rec_en = 1'b0;
    model_en = 1'b0;
    n_cmp++;
    if (dcount != 1) begin
      n_fail++;
      $display("FAIL pass_done_count: got %0d want 1", dcount);
    end
    n_cmp++;
    if (wr_addr.size() != 324) begin
      n_fail++;
      $display("FAIL pass_write_count: got %0d want 324", wr_addr.size());
    end
    for (int i = 0; i < wr_addr.size() && i < 324; i++) begin
`ifdef CONV_SEQ_INPLACE_ACC_EN
      exp_addr = i % 36;
      exp_acc  = (i >= 36) ? 1 : 0;
`else
      exp_addr = i;
      exp_acc  = 0;
`endif
      n_cmp++;
      if (wr_addr[i] != exp_addr || wr_acc[i] != exp_acc || wr_rd[i] != 1 || wr_kij[i] != i / 36) begin
        n_fail++;
        $display("FAIL pass_write[%0d]: got addr=%0d acc=%0d rd=%0d kij=%0d want %0d %0d 1 %0d",
                 i, wr_addr[i], wr_acc[i], wr_rd[i], wr_kij[i], exp_addr, exp_acc, i / 36);
      end
    end
    n_cmp++;
    if (inst !== IDLE_WORD) begin
      n_fail++;
      $display("FAIL pass_end_idle: got %h want %h", inst, IDLE_WORD);
    end
  endtask

  task automatic test_drain_spacing();
    bit hit;
    int n0;
    do_reset();
    force_valid = 1'b1;
    rec_en = 1'b1;
    pulse_start();
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      tick();
      hit = (kij_idx == 4'd1) && (inst[19] == 1'b0);
    end
    rec_en = 1'b0;
    force_valid = 1'b0;
    n_cmp++;
    if (!hit) begin
      n_fail++;
      $display("FAIL drain_reach: kij=1 not reached, got kij=%0d want 1", kij_idx);
    end
    n0 = 0;
    foreach (wr_kij[i]) if (wr_kij[i] == 0) n0++;
    n_cmp++;
    if (n0 != 36) begin
      n_fail++;
      $display("FAIL drain_count: got %0d want 36", n0);
    end
    n_cmp++;
    if (adj != 0) begin
      n_fail++;
      $display("FAIL drain_adjacent: got %0d adjacent ofifo_rd pairs want 0", adj);
    end
    n_cmp++;
    if (wr_addr.size() == 0 || wr_addr[wr_addr.size() - 1] != 35) begin
      n_fail++;
      $display("FAIL drain_last_addr: got %0d want 35",
               (wr_addr.size() == 0) ? -1 : wr_addr[wr_addr.size() - 1]);
    end
  endtask

  task automatic test_mid_reset();
    bit hit;
    do_reset();
    model_en = 1'b1;
    pulse_start();
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      tick();
      hit = (kij_idx == 4'd4) && (inst[1] == 1'b1);
    end
    n_cmp++;
    if (!hit) begin
      n_fail++;
      $display("FAIL midrst_reach: kij=4 execute not seen, got kij=%0d want 4", kij_idx);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (inst !== IDLE_WORD || busy !== 1'b0 || done !== 1'b0 || kij_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL midrst_async: got inst=%h busy=%b done=%b kij=%0d want %h 0 0 0",
               inst, busy, done, kij_idx, IDLE_WORD);
    end
    tick();
    tick();
    reset = 1'b0;
    model_en = 1'b0;
    tick();
    pulse_start();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_lat0: got busy=%b want 0", busy);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b1 || inst[19] !== 1'b0 || inst[17:7] !== 11'd1024 || kij_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL restart_first: got busy=%b cen=%b addr=%0d kij=%0d want 1 0 1024 0",
               busy, inst[19], inst[17:7], kij_idx);
    end
  endtask

  initial begin
    test_reset();
    test_weight_fetch();
    test_full_pass();
    test_drain_spacing();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_kij_sequencer.md
# conv_kij_sequencer

Hardware sequencer that drives the 34-bit `inst` bus of `core` through a full convolution pass: for each of `len_kij` kernel offsets it moves weights from activation/weight SRAM into L0 and the PE array, streams activations through L0 into the array, and drains OFIFO rows into psum SRAM. It replaces hand-written instruction sequencing and sits directly between the top-level start/done interface and `core`.

## Interface
Parameters:
- `row`, 8, PE array rows.
- `col`, 8, PE array columns; equals the number of weight words per kij.
- `len_kij`, 9, kernel offsets per pass.
- `len_nij`, 36, activation words per kij, which is also the OFIFO rows expected per kij.
- `gap_cycles`, 10, idle cycles between kernel load and execute.
- `x_base`, 11'd0, activation base address in xmem.
- `w_base`, 11'd1024, weight base address in xmem; the kij block sits at `w_base + kij*col`.
- `p_base`, 11'd0, psum base address in pmem.

Ports:
- `clk`  in  1  single clock, all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle pulse, accepted only in IDLE.
- `ofifo_valid`  in  1  from `core`: a complete OFIFO row is available.
- `inst`  out  34  instruction to `core`, registered.
  - [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem.
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem.
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the pass completes.
- `kij_idx`  out  4  index of the kij currently being processed.

## Operation
- FSM: IDLE → W_L0 → W_LOAD → GAP → X_EXEC → DRAIN → (W_L0 with kij+1, or FIN) → IDLE. A phase counter `c` restarts at 0 on every state entry.
- IDLE: `inst` sits at the idle word (all CEN/WEN = 1, all other bits 0). `start` sets kij=0 and moves to W_L0.
- W_L0, `col+1` cycles:
  - For c<col: CEN_xmem=0, WEN_xmem=1, A_xmem=`w_base+kij*col+c`.
  - For c≥1: l0_wr=1.
- W_LOAD, `col+row+1` cycles: l0_rd=1 every cycle; load=1 for c≥1.
- GAP: `gap_cycles` cycles with the idle word.
- X_EXEC, `len_nij+1` cycles:
  - For c<len_nij: CEN_xmem=0, WEN_xmem=1, A_xmem=`x_base+c`.
  - For c≥1: l0_wr=1, l0_rd=1, execute=1.
- DRAIN: the idle word, except for drain writes. Leaves when `wr_cnt==len_nij`.
- Drain writes run in X_EXEC and DRAIN. When `ofifo_valid`=1, the registered ofifo_rd is currently 0, and `wr_cnt<len_nij`, the next `inst` carries:
  - ofifo_rd=1, CEN_pmem=0, WEN_pmem=0.
  - A_pmem = `p_base + kij*len_nij + wr_cnt`.
  - wr_cnt is then incremented.
  - This limits drain throughput to at most one row every 2 cycles.
- `ofifo_valid` is ignored in IDLE, W_L0, W_LOAD and GAP, and after `wr_cnt` reaches `len_nij`.
- At the end of DRAIN, `wr_cnt` clears. If kij<len_kij-1, kij increments and the FSM returns to W_L0; otherwise it goes to FIN.
- FIN lasts 1 cycle: `done`=1, `inst` is the idle word, then IDLE.
- `start` is ignored while `busy`=1.
- Address arithmetic is 11-bit unsigned and wraps modulo 2048. No range check is performed.

## Timing
- Reset values: `inst`=34'h1_800C_0000, `busy`=0, `done`=0, `kij_idx`=0. FSM is in IDLE, kij=0, wr_cnt=0.
- Asserting `reset` mid-pass returns all state and outputs to these values immediately. The in-flight pass is abandoned; there is no resume.
- `start` sampled at edge N gives `busy`=1 and the first W_L0 `inst` word after edge N+1.
- All outputs are registered, so each `inst` field changes only on a clock edge.
- The drain write is issued 1 cycle after `ofifo_valid` is sampled. `core` writes the OFIFO output to pmem under that same instruction.
- Fixed cycles per kij excluding DRAIN: `(col+1)+(col+row+1)+gap_cycles+(len_nij+1)` = 9+17+10+37 = 73 at defaults.

## Configuration
- Macro `CONV_SEQ_INPLACE_ACC_EN`.
- Defined:
  - A_pmem = `p_base + wr_cnt`, with no kij offset.
  - acc (inst[33]) = 1 on drain writes for kij>0, so psums accumulate in place.
- Undefined:
  - Each kij writes its own region as described in Operation.
  - acc is always 0.

## Test plan
- Reset then idle: hold `reset` 5 cycles, release → `inst`=34'h1_800C_0000, `busy`=0, `done`=0; `start`=0 keeps this state indefinitely.
- Weight fetch: `start`, kij=1 → A_xmem reads 1032..1039 with CEN_xmem=0, l0_wr=1 on 8 cycles, then l0_rd=1 for 17 cycles and load=1 for 16 of them.
- Full pass, default params: a model `core` raises `ofifo_valid` for 36 rows per kij.
  - Exactly 324 pmem writes at addresses 0..323, each with ofifo_rd=1.
  - `done` pulses once; `busy` falls in the same cycle that FIN exits.
- Drain spacing: hold `ofifo_valid`=1 continuously → ofifo_rd alternates 1/0 and never sits high on adjacent cycles; writes stop at wr_cnt=36.
- Mid-pass reset: assert `reset` in X_EXEC of kij=4 → the idle word appears immediately. A later `start` begins again at kij=0, A_xmem=1024.
- With `CONV_SEQ_INPLACE_ACC_EN`: every kij writes pmem 0..35. acc=0 for kij=0 and acc=1 on all writes for kij 1..8.
